// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath with memory wait-state timeout.
// Ports: clk, rst_n, op, mem_ready in; datapath controls, bus_err, illegal_op, state out.
module mips_multicycle_control #(
  parameter int WAIT_LIMIT = 15,
  parameter int WCNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       irwrite,
  output logic [1:0] pcsource,
  output logic       aluop1,
  output logic       aluop0,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regwrite,
  output logic       regdst,
  output logic       bus_err,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [WCNT_W-1:0] LIMIT = WCNT_W'(WAIT_LIMIT);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              bus_err_q, bus_err_d;
  logic              illegal_q, illegal_d;
  logic              wait_st;
  logic              timeout;

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    wait_st   = 1'b0;
    case (state_q)
      S_FETCH: begin
        wait_st = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        wait_st = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        wait_st = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase

    // Ready on the limit cycle wins; only a stall at the limit aborts.
    timeout   = wait_st && !mem_ready && (wcnt_q == LIMIT);
    bus_err_d = timeout;
    if (timeout) state_d = S_FETCH;

    if (!wait_st || mem_ready || timeout || (state_d != state_q))
      wcnt_d = '0;
    else
      wcnt_d = wcnt_q + WCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wcnt_q    <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
    end
  end

  // Decoded from the state flop and gated by rst_n so that reset
  // silences every strobe at once, without waiting for an edge.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    pcsource    = 2'b00;
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE: alusrcb = 2'b11;
        S_MEMADR, S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop1  = 1'b1;
        end
        S_RWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BRANCH: begin
          alusrca     = 1'b1;
          aluop0      = 1'b1;
          pcwritecond = 1'b1;
          pcsource    = 2'b01;
        end
        S_JUMP: begin
          pcwrite  = 1'b1;
          pcsource = 2'b10;
        end
        S_ADDIWB: regwrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus_err    = bus_err_q;
  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: vector table plus
// hand sequences for timeout, limit-success and async reset.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pcwrite, pcwritecond, iord, memread, memwrite;
  logic       memtoreg, irwrite, aluop1, aluop0, alusrca;
  logic       regwrite, regdst, bus_err, illegal_op;
  logic [1:0] pcsource, alusrcb;
  logic [3:0] state;
  logic [17:0] act;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_multicycle_control #(.WAIT_LIMIT(15), .WCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .irwrite(irwrite), .pcsource(pcsource), .aluop1(aluop1),
    .aluop0(aluop0), .alusrca(alusrca), .alusrcb(alusrcb),
    .regwrite(regwrite), .regdst(regdst), .bus_err(bus_err),
    .illegal_op(illegal_op), .state(state)
  );

  assign act = {pcwrite, pcwritecond, iord, memread, memwrite,
                memtoreg, irwrite, pcsource, aluop1, aluop0,
                alusrca, alusrcb, regwrite, regdst, bus_err,
                illegal_op};

  // pcw pwc iord mrd mwr m2r irw pcs a1 a0 asa asb rw rd be il
  localparam logic [17:0] FW   = 18'b0_0_0_1_0_0_0_00_0_0_0_01_0_0_0_0;
  localparam logic [17:0] FR   = 18'b1_0_0_1_0_0_1_00_0_0_0_01_0_0_0_0;
  localparam logic [17:0] DEC  = 18'b0_0_0_0_0_0_0_00_0_0_0_11_0_0_0_0;
  localparam logic [17:0] MADR = 18'b0_0_0_0_0_0_0_00_0_0_1_10_0_0_0_0;
  localparam logic [17:0] MRD  = 18'b0_0_1_1_0_0_0_00_0_0_0_00_0_0_0_0;
  localparam logic [17:0] MWB  = 18'b0_0_0_0_0_1_0_00_0_0_0_00_1_0_0_0;
  localparam logic [17:0] MWR  = 18'b0_0_1_0_1_0_0_00_0_0_0_00_0_0_0_0;
  localparam logic [17:0] EXE  = 18'b0_0_0_0_0_0_0_00_1_0_1_00_0_0_0_0;
  localparam logic [17:0] RWB  = 18'b0_0_0_0_0_0_0_00_0_0_0_00_1_1_0_0;
  localparam logic [17:0] BR   = 18'b0_1_0_0_0_0_0_01_0_1_1_00_0_0_0_0;
  localparam logic [17:0] JMP  = 18'b1_0_0_0_0_0_0_10_0_0_0_00_0_0_0_0;
  localparam logic [17:0] AWB  = 18'b0_0_0_0_0_0_0_00_0_0_0_00_1_0_0_0;
  localparam logic [17:0] BE   = 18'b0_0_0_0_0_0_0_00_0_0_0_00_0_0_1_0;
  localparam logic [17:0] IL   = 18'b0_0_0_0_0_0_0_00_0_0_0_00_0_0_0_1;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JJ  = 6'b000010;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] ILL = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  opc;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] out;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [17:0] a,
                     input logic [17:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] o,
                      input logic rd, input logic [3:0] st,
                      input logic [17:0] ex, input string nm);
    @(negedge clk);
    rst_n = r;
    op = o;
    mem_ready = rd;
    #1;
    chk({nm, ".state"}, {14'd0, state}, {14'd0, st});
    chk({nm, ".out"}, act, ex);
  endtask

  initial begin
    tbl.push_back('{1'b0, LW, 1'b1, 4'd0, 18'd0});
    tbl.push_back('{1'b0, LW, 1'b1, 4'd0, 18'd0});
    tbl.push_back('{1'b0, LW, 1'b1, 4'd0, 18'd0});
    tbl.push_back('{1'b1, LW, 1'b1, 4'd0, FR});
    tbl.push_back('{1'b1, LW, 1'b1, 4'd1, DEC});
    tbl.push_back('{1'b1, LW, 1'b1, 4'd2, MADR});
    tbl.push_back('{1'b1, LW, 1'b1, 4'd3, MRD});
    tbl.push_back('{1'b1, LW, 1'b1, 4'd4, MWB});
    tbl.push_back('{1'b1, RT, 1'b1, 4'd0, FR});
    tbl.push_back('{1'b1, RT, 1'b1, 4'd1, DEC});
    tbl.push_back('{1'b1, RT, 1'b1, 4'd6, EXE});
    tbl.push_back('{1'b1, RT, 1'b1, 4'd7, RWB});
    tbl.push_back('{1'b1, BEQ, 1'b1, 4'd0, FR});
    tbl.push_back('{1'b1, BEQ, 1'b1, 4'd1, DEC});
    tbl.push_back('{1'b1, BEQ, 1'b1, 4'd8, BR});
    tbl.push_back('{1'b1, JJ, 1'b1, 4'd0, FR});
    tbl.push_back('{1'b1, JJ, 1'b1, 4'd1, DEC});
    tbl.push_back('{1'b1, JJ, 1'b1, 4'd9, JMP});
    tbl.push_back('{1'b1, ADI, 1'b1, 4'd0, FR});
    tbl.push_back('{1'b1, ADI, 1'b1, 4'd1, DEC});
    tbl.push_back('{1'b1, ADI, 1'b1, 4'd10, MADR});
    tbl.push_back('{1'b1, ADI, 1'b1, 4'd11, AWB});
    tbl.push_back('{1'b1, ILL, 1'b1, 4'd0, FR});
    tbl.push_back('{1'b1, ILL, 1'b1, 4'd1, DEC});
    tbl.push_back('{1'b1, SW, 1'b1, 4'd0, FR | IL});
    tbl.push_back('{1'b1, SW, 1'b1, 4'd1, DEC});
    tbl.push_back('{1'b1, SW, 1'b1, 4'd2, MADR});
    tbl.push_back('{1'b1, LW, 1'b0, 4'd5, MWR});
    tbl.push_back('{1'b1, LW, 1'b0, 4'd5, MWR});
    tbl.push_back('{1'b1, LW, 1'b0, 4'd5, MWR});
    tbl.push_back('{1'b1, LW, 1'b1, 4'd5, MWR});
    tbl.push_back('{1'b1, SW, 1'b1, 4'd0, FR});

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].opc, tbl[i].rdy, tbl[i].st,
           tbl[i].out, $sformatf("vec%0d", i));

    // Timeout in MEMRD: 16 cycles in the state, abort to FETCH.
    step(1'b1, LW, 1'b1, 4'd1, DEC, "to_dec");
    step(1'b1, LW, 1'b1, 4'd2, MADR, "to_madr");
    for (int i = 0; i < 16; i++)
      step(1'b1, LW, 1'b0, 4'd3, MRD, $sformatf("mrd_stall%0d", i));
    step(1'b1, LW, 1'b0, 4'd0, FW | BE, "mrd_timeout");
    step(1'b1, LW, 1'b0, 4'd0, FW, "be_one_cycle");

    // Fetch stall keeps timing out into FETCH itself.
    for (int i = 0; i < 14; i++)
      step(1'b1, LW, 1'b0, 4'd0, FW, $sformatf("f_stall%0d", i));
    step(1'b1, LW, 1'b0, 4'd0, FW | BE, "fetch_timeout");
    step(1'b1, SW, 1'b1, 4'd0, FR, "fetch_resume");

    // Ready on the limit cycle is a success.
    step(1'b1, SW, 1'b1, 4'd1, DEC, "sw_dec");
    step(1'b1, SW, 1'b1, 4'd2, MADR, "sw_madr");
    for (int i = 0; i < 15; i++)
      step(1'b1, SW, 1'b0, 4'd5, MWR, $sformatf("mwr_stall%0d", i));
    step(1'b1, SW, 1'b1, 4'd5, MWR, "mwr_limit_ready");
    step(1'b1, SW, 1'b1, 4'd0, FR, "no_bus_err");

    // Async reset during MEMWR.
    step(1'b1, SW, 1'b1, 4'd1, DEC, "rst_dec");
    step(1'b1, SW, 1'b1, 4'd2, MADR, "rst_madr");
    step(1'b1, SW, 1'b0, 4'd5, MWR, "rst_mwr");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.memwrite", {17'd0, memwrite}, 18'd0);
    chk("async_rst.state", {14'd0, state}, 18'd0);
    chk("async_rst.out", act, 18'd0);
    step(1'b0, SW, 1'b1, 4'd0, 18'd0, "rst_hold");
    step(1'b1, SW, 1'b1, 4'd0, FR, "rst_release");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
